// File: rtl/cdp1802_dma_responder.sv
// CPU-side responder for 1861-style video DMA/interrupt cycles: steals S2/S3 machine cycles from the 1802 core.
// Optional DMA-in write path enabled by defining DMA_IN_EN.
module cdp1802_dma_responder #(
   parameter int TICKS_PER_CYCLE = 8,
   parameter int RD_TICK         = 2,
   parameter int LATCH_TICK      = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic [1:0]  core_sc,
   input  logic        core_last,
   input  logic        dma_out_n,
   input  logic        int_req,
   input  logic        ie_set,
   input  logic        ie_clr,
   input  logic        r0_load,
   input  logic [15:0] r0_value,
   input  logic [7:0]  mem_rdata,
`ifdef DMA_IN_EN
   input  logic        dma_in_n,
   input  logic [7:0]  dma_in_data,
   output logic        mem_wr,
   output logic [7:0]  mem_wdata,
`endif
   output logic [1:0]  sc,
   output logic        core_stall,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   output logic [7:0]  dma_data,
   output logic        dma_strobe,
   output logic        int_ack,
   output logic [15:0] r0,
   output logic        ie
);

   localparam int TW = (TICKS_PER_CYCLE > 1) ? $clog2(TICKS_PER_CYCLE) : 1;
   localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_CYCLE - 1);
   localparam logic [TW-1:0] RD_T      = TW'(RD_TICK);
   localparam logic [TW-1:0] LATCH_T   = TW'(LATCH_TICK);

   typedef enum logic [1:0] {ST_CORE, ST_S2, ST_S3} state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic          dir_in_q, dir_in_d;
   logic [15:0]   r0_q, r0_d;
   logic          ie_q, ie_d;
   logic [1:0]    sc_q, sc_d;
   logic          core_stall_q, core_stall_d;
   logic [15:0]   mem_addr_q, mem_addr_d;
   logic          mem_rd_q, mem_rd_d;
   logic [7:0]    dma_data_q, dma_data_d;
   logic          dma_strobe_q, dma_strobe_d;
   logic          int_ack_q, int_ack_d;
   logic          mem_wr_q, mem_wr_d;
   logic [7:0]    mem_wdata_q, mem_wdata_d;
   logic          boundary;
   logic          decide;
   logic          in_req;
   logic [7:0]    in_data;

`ifdef DMA_IN_EN
   assign in_req  = ~dma_in_n;
   assign in_data = dma_in_data;
`else
   assign in_req  = 1'b0;
   assign in_data = 8'h00;
`endif

   // State register: every flop in the block, synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_CORE;
         tick_q       <= '0;
         dir_in_q     <= 1'b0;
         r0_q         <= 16'h0000;
         ie_q         <= 1'b1;
         sc_q         <= core_sc;
         core_stall_q <= 1'b0;
         mem_addr_q   <= 16'h0000;
         mem_rd_q     <= 1'b0;
         dma_data_q   <= 8'h00;
         dma_strobe_q <= 1'b0;
         int_ack_q    <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_wdata_q  <= 8'h00;
      end else begin
         state_q      <= state_d;
         tick_q       <= tick_d;
         dir_in_q     <= dir_in_d;
         r0_q         <= r0_d;
         ie_q         <= ie_d;
         sc_q         <= sc_d;
         core_stall_q <= core_stall_d;
         mem_addr_q   <= mem_addr_d;
         mem_rd_q     <= mem_rd_d;
         dma_data_q   <= dma_data_d;
         dma_strobe_q <= dma_strobe_d;
         int_ack_q    <= int_ack_d;
         mem_wr_q     <= mem_wr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   // Requests are only looked at on the boundary tick; priority DMA-in > DMA-out > interrupt.
   always_comb begin
      boundary = clk_enable && (tick_q == LAST_TICK);
      decide   = boundary && (((state_q == ST_CORE) && (core_sc == 2'b01) && core_last) ||
                              (state_q == ST_S2));
      tick_d   = tick_q;
      state_d  = state_q;
      dir_in_d = dir_in_q;
      if (clk_enable) begin
         tick_d = boundary ? '0 : tick_q + 1'b1;
      end
      if (boundary && (state_q == ST_S3)) begin
         state_d = ST_CORE;
      end else if (decide) begin
         if (in_req) begin
            state_d  = ST_S2;
            dir_in_d = 1'b1;
         end else if (!dma_out_n) begin
            state_d  = ST_S2;
            dir_in_d = 1'b0;
         end else if (int_req && ie_q) begin
            state_d = ST_S3;
         end else begin
            state_d = ST_CORE;
         end
      end
   end

   // R0 belongs to the DMA pointer during S2; entering S3 clears IE ahead of any set/clear pulse.
   always_comb begin
      r0_d = r0_q;
      ie_d = ie_q;
      if (clk_enable) begin
         if ((state_q == ST_S2) && boundary) begin
            r0_d = r0_q + 16'h0001;
         end else if ((state_q != ST_S2) && r0_load) begin
            r0_d = r0_value;
         end
         if (boundary && (state_d == ST_S3)) begin
            ie_d = 1'b0;
         end else if (ie_clr) begin
            ie_d = 1'b0;
         end else if (ie_set) begin
            ie_d = 1'b1;
         end
      end
   end

   // Outputs are computed from the upcoming state/tick so they line up with the cycle they describe.
   always_comb begin
      sc_d         = sc_q;
      core_stall_d = core_stall_q;
      mem_addr_d   = mem_addr_q;
      mem_rd_d     = mem_rd_q;
      dma_data_d   = dma_data_q;
      dma_strobe_d = dma_strobe_q;
      int_ack_d    = int_ack_q;
      mem_wr_d     = mem_wr_q;
      mem_wdata_d  = mem_wdata_q;
      if (clk_enable) begin
         case (state_d)
            ST_S2:   sc_d = 2'b10;
            ST_S3:   sc_d = 2'b11;
            default: sc_d = core_sc;
         endcase
         core_stall_d = (state_d != ST_CORE);
         mem_addr_d   = (state_d == ST_S2) ? r0_d : 16'h0000;
         mem_rd_d     = (state_d == ST_S2) && !dir_in_d && (tick_d == RD_T);
         dma_strobe_d = (state_d == ST_S2) && !dir_in_d && (tick_d == LATCH_T);
         mem_wr_d     = (state_d == ST_S2) && dir_in_d && (tick_d == RD_T);
         int_ack_d    = (state_d == ST_S3) && (tick_d == '0);
         if (dma_strobe_d) begin
            dma_data_d = mem_rdata;
         end
         if (mem_wr_d) begin
            mem_wdata_d = in_data;
         end
      end
   end

   assign sc         = sc_q;
   assign core_stall = core_stall_q;
   assign mem_addr   = mem_addr_q;
   assign mem_rd     = mem_rd_q;
   assign dma_data   = dma_data_q;
   assign dma_strobe = dma_strobe_q;
   assign int_ack    = int_ack_q;
   assign r0         = r0_q;
   assign ie         = ie_q;
`ifdef DMA_IN_EN
   assign mem_wr     = mem_wr_q;
   assign mem_wdata  = mem_wdata_q;
`endif

endmodule

// File: tb/tb_cdp1802_dma_responder.sv
// Directed self-checking bench for cdp1802_dma_responder (default build, DMA-in disabled).
module tb_cdp1802_dma_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_enable;
   logic [1:0]  core_sc;
   logic        core_last;
   logic        dma_out_n;
   logic        int_req;
   logic        ie_set;
   logic        ie_clr;
   logic        r0_load;
   logic [15:0] r0_value;
   logic [7:0]  mem_rdata;
   logic [1:0]  sc;
   logic        core_stall;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  dma_data;
   logic        dma_strobe;
   logic        int_ack;
   logic [15:0] r0;
   logic        ie;

   int testCount = 0;
   int failCount = 0;
   int tbTick = 0;

   cdp1802_dma_responder dut (
      .clk        (clk),
      .reset      (reset),
      .clk_enable (clk_enable),
      .core_sc    (core_sc),
      .core_last  (core_last),
      .dma_out_n  (dma_out_n),
      .int_req    (int_req),
      .ie_set     (ie_set),
      .ie_clr     (ie_clr),
      .r0_load    (r0_load),
      .r0_value   (r0_value),
      .mem_rdata  (mem_rdata),
      .sc         (sc),
      .core_stall (core_stall),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .dma_data   (dma_data),
      .dma_strobe (dma_strobe),
      .int_ack    (int_ack),
      .r0         (r0),
      .ie         (ie)
   );

   always #5 clk = ~clk;

   // Reference machine-cycle tick counter (clk_enable held high).
   always @(posedge clk) begin
      if (reset) tbTick <= 0;
      else if (clk_enable) tbTick <= (tbTick + 1) % 8;
   end

   function automatic logic [7:0] memByte(input logic [15:0] a);
      if (a == 16'h0900) return 8'hA5;
      return a[7:0] ^ 8'h3C;
   endfunction

   assign mem_rdata = memByte(mem_addr);

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic dmaN, input logic intr);
      dma_out_n = dmaN;
      int_req   = intr;
   endtask

   // Advance to the next falling edge at which the reference tick equals t.
   task automatic waitTick(input int t);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tbTick != t && n < 64);
      if (tbTick != t) checkOutput("waitTick_timeout", 16'(tbTick), 16'(t));
   endtask

   task automatic pulseR0(input logic [15:0] v);
      r0_value = v;
      r0_load  = 1'b1;
      @(negedge clk);
      r0_load  = 1'b0;
   endtask

   initial begin
      reset = 1'b1; clk_enable = 1'b1; core_sc = 2'b01; core_last = 1'b1;
      ie_set = 1'b0; ie_clr = 1'b0; r0_load = 1'b0; r0_value = 16'h0000;
      applyStimulus(1'b1, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("rst_sc", 16'(sc), 16'h0001);
      checkOutput("rst_stall", 16'(core_stall), 16'h0000);
      checkOutput("rst_addr", mem_addr, 16'h0000);
      checkOutput("rst_rd", 16'(mem_rd), 16'h0000);
      checkOutput("rst_data", 16'(dma_data), 16'h0000);
      checkOutput("rst_strobe", 16'(dma_strobe), 16'h0000);
      checkOutput("rst_intack", 16'(int_ack), 16'h0000);
      checkOutput("rst_r0", r0, 16'h0000);
      checkOutput("rst_ie", 16'(ie), 16'h0001);
      reset = 1'b0;

      // Eight-byte DMA burst from 0x0900
      pulseR0(16'h0900);
      checkOutput("r0_load", r0, 16'h0900);
      waitTick(7);
      checkOutput("core_before_dma", 16'(core_stall), 16'h0000);
      applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         waitTick(0);
         checkOutput("s2_sc", 16'(sc), 16'h0002);
         checkOutput("s2_stall", 16'(core_stall), 16'h0001);
         checkOutput("s2_addr", mem_addr, 16'h0900 + 16'(i));
         if (i == 0) begin
            waitTick(1);
            checkOutput("s2_rd_t1", 16'(mem_rd), 16'h0000);
         end
         waitTick(2);
         checkOutput("s2_rd_t2", 16'(mem_rd), 16'h0001);
         waitTick(4);
         checkOutput("s2_strobe_t4", 16'(dma_strobe), 16'h0000);
         checkOutput("s2_rd_t4", 16'(mem_rd), 16'h0000);
         waitTick(5);
         checkOutput("s2_strobe_t5", 16'(dma_strobe), 16'h0001);
         checkOutput("s2_data", 16'(dma_data), 16'(memByte(16'h0900 + 16'(i))));
         waitTick(6);
         checkOutput("s2_strobe_t6", 16'(dma_strobe), 16'h0000);
         checkOutput("s2_stall_t6", 16'(core_stall), 16'h0001);
         if (i == 7) applyStimulus(1'b1, 1'b0);
      end
      waitTick(0);
      checkOutput("burst_r0", r0, 16'h0908);
      checkOutput("burst_end_stall", 16'(core_stall), 16'h0000);
      checkOutput("burst_end_sc", 16'(sc), 16'h0001);
      checkOutput("burst_end_addr", mem_addr, 16'h0000);
      checkOutput("burst_keep_data", 16'(dma_data), 16'(memByte(16'h0907)));

      // Interrupt cycle, then IE blocks a second request
      applyStimulus(1'b1, 1'b1);
      waitTick(0);
      checkOutput("s3_sc", 16'(sc), 16'h0003);
      checkOutput("s3_stall", 16'(core_stall), 16'h0001);
      checkOutput("s3_intack", 16'(int_ack), 16'h0001);
      checkOutput("s3_ie", 16'(ie), 16'h0000);
      waitTick(1);
      checkOutput("s3_intack_t1", 16'(int_ack), 16'h0000);
      waitTick(0);
      checkOutput("after_s3_stall", 16'(core_stall), 16'h0000);
      checkOutput("after_s3_sc", 16'(sc), 16'h0001);
      waitTick(0);
      checkOutput("int_masked_stall", 16'(core_stall), 16'h0000);
      ie_set = 1'b1;
      @(negedge clk);
      ie_set = 1'b0;
      checkOutput("ie_set", 16'(ie), 16'h0001);
      waitTick(0);
      checkOutput("s3_again_sc", 16'(sc), 16'h0003);
      checkOutput("s3_again_ie", 16'(ie), 16'h0000);
      applyStimulus(1'b1, 1'b0);
      waitTick(0);
      checkOutput("s3_again_end", 16'(core_stall), 16'h0000);
      ie_set = 1'b1; ie_clr = 1'b1;
      @(negedge clk);
      ie_set = 1'b0; ie_clr = 1'b0;
      checkOutput("ie_clr_wins", 16'(ie), 16'h0000);
      ie_set = 1'b1;
      @(negedge clk);
      ie_set = 1'b0;
      checkOutput("ie_set2", 16'(ie), 16'h0001);

      // DMA beats interrupt, R0 wraps, interrupt follows once DMAO releases
      pulseR0(16'hFFFF);
      checkOutput("r0_ffff", r0, 16'hFFFF);
      applyStimulus(1'b0, 1'b1);
      waitTick(0);
      checkOutput("prio_sc", 16'(sc), 16'h0002);
      checkOutput("prio_addr", mem_addr, 16'hFFFF);
      checkOutput("prio_ie", 16'(ie), 16'h0001);
      pulseR0(16'h1111);
      checkOutput("r0_load_ignored_s2", r0, 16'hFFFF);
      applyStimulus(1'b1, 1'b1);
      waitTick(0);
      checkOutput("post_dma_sc", 16'(sc), 16'h0003);
      checkOutput("wrap_r0", r0, 16'h0000);
      checkOutput("post_dma_intack", 16'(int_ack), 16'h0001);
      applyStimulus(1'b1, 1'b0);
      waitTick(0);
      checkOutput("prio_end", 16'(core_stall), 16'h0000);

      // Reset in the middle of an S2 cycle
      pulseR0(16'h1234);
      applyStimulus(1'b0, 1'b0);
      waitTick(0);
      checkOutput("pre_rst_sc", 16'(sc), 16'h0002);
      waitTick(4);
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0);
      @(negedge clk);
      checkOutput("midrst_stall", 16'(core_stall), 16'h0000);
      checkOutput("midrst_r0", r0, 16'h0000);
      checkOutput("midrst_strobe", 16'(dma_strobe), 16'h0000);
      checkOutput("midrst_ie", 16'(ie), 16'h0001);
      checkOutput("midrst_addr", mem_addr, 16'h0000);
      checkOutput("midrst_sc", 16'(sc), 16'h0001);
      reset = 1'b0;
      waitTick(5);
      checkOutput("midrst_no_strobe", 16'(dma_strobe), 16'h0000);
      checkOutput("midrst_core", 16'(core_stall), 16'h0000);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
